// File: rtl/tsc_pkg.sv
// Shared types and helpers for the tolerance stream checker: run-state enum
// and the per-lane modular tolerance compare.
package tsc_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_ABORT = 2'd2,
        S_DONE  = 2'd3
    } tsc_state_e;

    // Samples are zero-extended to 32 bits; the difference is reduced mod 2^dw so
    // small negative errors wrap to the top of the range and still pass.
    function automatic logic lane_ok(input logic [31:0] act, input logic [31:0] gold,
                                     input int unsigned dw, input int unsigned tol);
        logic [32:0] modv;
        logic [32:0] diff;
        modv = 33'd1 << dw;
        diff = ({1'b0, act} - {1'b0, gold}) & (modv - 33'd1);
        return (diff <= 33'(tol)) || (diff >= modv - 33'(tol));
    endfunction

endpackage

// File: rtl/tsc_fifo.sv
// Synchronous buffer for actual beats. A push into a full buffer is accepted
// only if a pop happens in the same cycle; otherwise it is dropped.
module tsc_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !(rst || clr)) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/tol_stream_checker.sv
// Compares a buffered actual stream against a golden stream lane by lane within
// a modular tolerance. Define TSC_FIRST_FAIL_EN to capture the first mismatch.
module tol_stream_checker
    import tsc_pkg::*;
#(
    parameter int DW         = 16,
    parameter int LANES      = 16,
    parameter int TOL        = 3,
    parameter int DEPTH      = 4,
    parameter int NUM_BEATS  = 64,
    parameter int WIN        = 1,
    parameter int FAIL_LIMIT = 48,
    localparam int IW  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1,
    localparam int EW  = $clog2(FAIL_LIMIT + 1),
    localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                act_valid,
    input  logic [LANES*DW-1:0] act_data,
    input  logic                exp_valid,
    output logic                exp_ready,
    input  logic [LANES*DW-1:0] exp_data,
    output logic                mm_valid,
    output logic [LANES-1:0]    mm_mask,
    output logic [IW-1:0]       mm_idx,
    output logic [EW-1:0]       err_cnt,
    output logic                win_done,
    output logic                win_pass,
    output logic                overflow,
    output logic                abort,
    output logic                done,
    output logic                pass,
    output logic [IW-1:0]       ff_idx,
    output logic [LW-1:0]       ff_lane,
    output logic [DW-1:0]       ff_act,
    output logic [DW-1:0]       ff_exp,
    output tsc_state_e          dbg_state
);
    localparam int WCW = (WIN > 1) ? $clog2(WIN) : 1;

    tsc_state_e          state, state_next;
    logic                clr, push, pop;
    logic                fifo_full, fifo_empty;
    logic [LANES*DW-1:0] head;
    logic [LANES-1:0]    lane_fail;
    logic [31:0]         err_sum;
    logic [EW-1:0]       err_next;
    logic [IW-1:0]       beat_cnt;
    logic [WCW-1:0]      win_cnt;
    logic                win_err;
    logic                win_last;

    // Handshake: exp_valid/exp_ready is a valid/ready pair; a beat transfers on a
    // cycle where both are high. act_valid has no ready and is taken as presented.
    assign clr       = start && (state != S_RUN);
    assign push      = (state == S_RUN) && act_valid;
    assign exp_ready = (state == S_RUN) && !fifo_empty && exp_valid;
    assign pop       = exp_ready;
    assign win_last  = (win_cnt == WCW'(WIN - 1));

    tsc_fifo #(.WIDTH(LANES*DW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .wdata (act_data),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        lane_fail = '0;
        err_sum   = 32'(err_cnt);
        for (int l = 0; l < LANES; l++) begin
            lane_fail[l] = !lane_ok(32'(head[l*DW +: DW]), 32'(exp_data[l*DW +: DW]), DW, TOL);
            err_sum      = err_sum + 32'(lane_fail[l]);
        end
        err_next = (err_sum >= 32'(FAIL_LIMIT)) ? EW'(FAIL_LIMIT) : EW'(err_sum);
    end

    // Abort takes priority if the final beat also pushes the count to the limit.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN: begin
                if (pop) begin
                    if (err_next == EW'(FAIL_LIMIT))       state_next = S_ABORT;
                    else if (beat_cnt == IW'(NUM_BEATS-1)) state_next = S_DONE;
                end
            end
            S_ABORT: if (start) state_next = S_RUN;
            S_DONE:  if (start) state_next = S_RUN;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            mm_valid <= 1'b0;
            mm_mask  <= '0;
            mm_idx   <= '0;
            beat_cnt <= '0;
            err_cnt  <= '0;
            win_cnt  <= '0;
            win_err  <= 1'b0;
            win_done <= 1'b0;
            win_pass <= 1'b0;
            overflow <= 1'b0;
        end else begin
            mm_valid <= pop;
            win_done <= pop && win_last;
            win_pass <= pop && win_last && !(win_err || (|lane_fail));
            if (pop) begin
                mm_mask  <= lane_fail;
                mm_idx   <= beat_cnt;
                beat_cnt <= beat_cnt + 1'b1;
                err_cnt  <= err_next;
                if (win_last) begin
                    win_cnt <= '0;
                    win_err <= 1'b0;
                end else begin
                    win_cnt <= win_cnt + 1'b1;
                    win_err <= win_err || (|lane_fail);
                end
            end
            if (push && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    assign abort     = (state == S_ABORT);
    assign done      = (state == S_DONE);
    assign pass      = done && (err_cnt == '0) && !overflow;
    assign dbg_state = state;

`ifdef TSC_FIRST_FAIL_EN
    logic          ff_seen;
    logic [LW-1:0] first_lane;

    always_comb begin
        first_lane = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (lane_fail[l]) first_lane = LW'(l);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ff_seen <= 1'b0;
            ff_idx  <= '0;
            ff_lane <= '0;
            ff_act  <= '0;
            ff_exp  <= '0;
        end else if (pop && (|lane_fail) && !ff_seen) begin
            ff_seen <= 1'b1;
            ff_idx  <= beat_cnt;
            ff_lane <= first_lane;
            ff_act  <= head[first_lane*DW +: DW];
            ff_exp  <= exp_data[first_lane*DW +: DW];
        end
    end
`else
    assign ff_idx  = '0;
    assign ff_lane = '0;
    assign ff_act  = '0;
    assign ff_exp  = '0;
`endif

endmodule

// File: tb/tb_tol_stream_checker.sv
// Directed bench for tol_stream_checker: table vectors for the tolerance edge,
// plus hand-written runs for overflow, abort, mid-run reset and first-failure.
module tb_tol_stream_checker;
  import tsc_pkg::*;

  localparam int DW         = 16;
  localparam int LANES      = 16;
  localparam int TOL        = 3;
  localparam int DEPTH      = 4;
  localparam int NUM_BEATS  = 64;
  localparam int WIN        = 1;
  localparam int FAIL_LIMIT = 48;
  localparam int IW = $clog2(NUM_BEATS);
  localparam int EW = $clog2(FAIL_LIMIT + 1);
  localparam int LW = $clog2(LANES);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                act_valid = 1'b0;
  logic [LANES*DW-1:0] act_data = '0;
  logic                exp_valid = 1'b0;
  logic                exp_ready;
  logic [LANES*DW-1:0] exp_data = '0;
  logic                mm_valid;
  logic [LANES-1:0]    mm_mask;
  logic [IW-1:0]       mm_idx;
  logic [EW-1:0]       err_cnt;
  logic                win_done, win_pass, overflow, abort, done, pass;
  logic [IW-1:0]       ff_idx;
  logic [LW-1:0]       ff_lane;
  logic [DW-1:0]       ff_act, ff_exp;
  tsc_state_e          dbg_state;

  tol_stream_checker #(
    .DW(DW), .LANES(LANES), .TOL(TOL), .DEPTH(DEPTH),
    .NUM_BEATS(NUM_BEATS), .WIN(WIN), .FAIL_LIMIT(FAIL_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .act_valid(act_valid), .act_data(act_data),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data),
    .mm_valid(mm_valid), .mm_mask(mm_mask), .mm_idx(mm_idx), .err_cnt(err_cnt),
    .win_done(win_done), .win_pass(win_pass), .overflow(overflow),
    .abort(abort), .done(done), .pass(pass),
    .ff_idx(ff_idx), .ff_lane(ff_lane), .ff_act(ff_act), .ff_exp(ff_exp),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [LANES-1:0] exp_q[$];
  int               sb_idx = 0;
  int               sb_err = 0;
  int               win_seen = 0;
  logic [LANES-1:0] err_tab [NUM_BEATS];

  typedef struct {
    logic [DW-1:0] act0;
    logic [DW-1:0] gold0;
    logic          fail0;
  } vec_t;
  vec_t tab [8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, want);
  endtask

  function automatic logic [DW-1:0] samp(input int b, input int l);
    return DW'(b * 37 + l * 101 + 32'h7ff0);
  endfunction

  function automatic logic [LANES*DW-1:0] beat(input int b, input logic [LANES-1:0] bad);
    logic [LANES*DW-1:0] v;
    for (int l = 0; l < LANES; l++)
      v[l*DW +: DW] = samp(b, l) + (bad[l] ? 16'h0100 : 16'h0000);
    return v;
  endfunction

  // scoreboard: every compare result is matched against the expected queue
  always @(negedge clk) begin
    logic [LANES-1:0] m;
    if (win_done) win_seen++;
    if (mm_valid) begin
      if (exp_q.size() == 0) begin
        check("mm_unexpected", 1, 0);
      end else begin
        m = exp_q.pop_front();
        sb_err = sb_err + $countones(m);
        if (sb_err > FAIL_LIMIT) sb_err = FAIL_LIMIT;
        check("mm_mask", 64'(mm_mask), 64'(m));
        check("mm_idx", 64'(mm_idx), 64'(sb_idx));
        check("err_cnt", 64'(err_cnt), 64'(sb_err));
        check("win_done", 64'(win_done), 1);
        check("win_pass", 64'(win_pass), 64'(m == '0));
        check("abort_timing", 64'(abort), 64'(sb_err >= FAIL_LIMIT));
        check("done_timing", 64'(done), 64'((sb_idx == NUM_BEATS - 1) && (sb_err < FAIL_LIMIT)));
        sb_idx++;
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_clear();
    exp_q.delete();
    sb_idx = 0;
    sb_err = 0;
    win_seen = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    act_valid = 1'b0;
    exp_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    sb_clear();
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic push_act(input logic [LANES*DW-1:0] a);
    act_valid = 1'b1;
    act_data  = a;
    exp_valid = 1'b0;
    cyc();
    act_valid = 1'b0;
  endtask

  task automatic pop_exp(input logic [LANES*DW-1:0] g);
    act_valid = 1'b0;
    exp_valid = 1'b1;
    exp_data  = g;
    cyc();
    exp_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] g);
    push_act(a);
    pop_exp(g);
  endtask

  // Back-to-back stream with exp_valid held high; golden lags actual by one cycle.
  task automatic stream(input int n, input int ncmp);
    for (int i = 0; i < ncmp; i++) exp_q.push_back(err_tab[i]);
    for (int i = 0; i <= n; i++) begin
      act_valid = (i < n);
      act_data  = beat(i, (i < n) ? err_tab[i] : '0);
      exp_valid = 1'b1;
      exp_data  = beat((i > 0) ? i - 1 : 0, '0);
      cyc();
    end
    check("exp_ready_hold", 64'(exp_ready), 0);
    act_valid = 1'b0;
    exp_valid = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_exp_ready"}, 64'(exp_ready), 0);
    check({tag, "_mm_valid"}, 64'(mm_valid), 0);
    check({tag, "_mm_mask"}, 64'(mm_mask), 0);
    check({tag, "_mm_idx"}, 64'(mm_idx), 0);
    check({tag, "_err_cnt"}, 64'(err_cnt), 0);
    check({tag, "_win"}, 64'({win_done, win_pass}), 0);
    check({tag, "_flags"}, 64'({overflow, abort, done, pass}), 0);
    check({tag, "_ff"}, 64'({ff_idx, ff_lane, ff_act, ff_exp}), 0);
    check({tag, "_state"}, 64'(dbg_state), 64'(S_IDLE));
  endtask

  initial begin
    tab[0] = '{16'hfffd, 16'h0000, 1'b0};
    tab[1] = '{16'hfffc, 16'h0000, 1'b1};
    tab[2] = '{16'h0003, 16'h0000, 1'b0};
    tab[3] = '{16'h0004, 16'h0000, 1'b1};
    tab[4] = '{16'h7fff, 16'h8002, 1'b0};
    tab[5] = '{16'h8000, 16'h7ffc, 1'b1};
    tab[6] = '{16'h1234, 16'h1234, 1'b0};
    tab[7] = '{16'h0000, 16'hfffd, 1'b0};

    // reset state
    do_reset();
    check_idle("reset");

    // table-driven tolerance vectors on lane 0
    do_start();
    check("run_state", 64'(dbg_state), 64'(S_RUN));
    for (int k = 0; k < 8; k++) begin
      logic [LANES*DW-1:0] a, g;
      a = beat(k, '0);
      g = a;
      a[DW-1:0] = tab[k].act0;
      g[DW-1:0] = tab[k].gold0;
      exp_q.push_back({{(LANES-1){1'b0}}, tab[k].fail0});
      send_beat(a, g);
    end
    cyc();
    check("tab_drained", 64'(exp_q.size()), 0);
    check("tab_err_cnt", 64'(err_cnt), 3);
    check("tab_state", 64'(dbg_state), 64'(S_RUN));

    // clean 64-beat streaming run
    do_reset();
    for (int i = 0; i < NUM_BEATS; i++) err_tab[i] = '0;
    do_start();
    stream(NUM_BEATS, NUM_BEATS);
    check("clean_done", 64'(done), 1);
    check("clean_pass", 64'(pass), 1);
    check("clean_err", 64'(err_cnt), 0);
    check("clean_windows", 64'(win_seen), 64);
    check("clean_beats", 64'(sb_idx), 64);

    // overflow: five actual beats with no golden consumption
    do_reset();
    do_start();
    for (int i = 0; i < 4; i++) push_act(beat(i, '0));
    check("ovf_before", 64'(overflow), 0);
    push_act(beat(4, '0));
    check("ovf_set", 64'(overflow), 1);
    for (int i = 0; i < NUM_BEATS; i++) exp_q.push_back('0);
    for (int i = 0; i < 4; i++) pop_exp(beat(i, '0));
    for (int i = 4; i < NUM_BEATS; i++) send_beat(beat(i, '0), beat(i, '0));
    cyc();
    check("ovf_done", 64'(done), 1);
    check("ovf_pass", 64'(pass), 0);
    check("ovf_err", 64'(err_cnt), 0);
    check("ovf_drained", 64'(exp_q.size()), 0);

    // abort: all lanes wrong from beat 2
    do_reset();
    for (int i = 0; i < NUM_BEATS; i++) err_tab[i] = (i >= 2) ? '1 : '0;
    do_start();
    stream(NUM_BEATS, 5);
    check("abort_flag", 64'(abort), 1);
    check("abort_err", 64'(err_cnt), 48);
    check("abort_done", 64'({done, pass}), 0);
    check("abort_beats", 64'(sb_idx), 5);
    check("abort_drained", 64'(exp_q.size()), 0);

    // reset in the middle of a run, with a compare in flight
    do_reset();
    do_start();
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back((i == 3) ? 16'h0001 : 16'h0000);
      send_beat(beat(i, (i == 3) ? 16'h0001 : 16'h0000), beat(i, '0));
    end
    push_act(beat(10, '0));
    check("mid_err_before", 64'(err_cnt), 1);
    exp_valid = 1'b1;
    exp_data  = beat(10, '0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_valid = 1'b0;
    check_idle("midrst");
    cyc();
    check("mid_no_inflight", 64'(exp_q.size() + sb_idx), 10);
    sb_clear();
    for (int i = 0; i < NUM_BEATS; i++) err_tab[i] = '0;
    do_start();
    stream(NUM_BEATS, NUM_BEATS);
    check("mid_rerun_pass", 64'(pass), 1);

    // first-failure record: lanes 5 and 9 at beat 7, later failures after
    do_reset();
    for (int i = 0; i < NUM_BEATS; i++) err_tab[i] = '0;
    err_tab[7]  = 16'h0220;
    err_tab[9]  = 16'h0001;
    err_tab[20] = 16'h0008;
    do_start();
    stream(NUM_BEATS, NUM_BEATS);
    check("ff_run_err", 64'(err_cnt), 4);
    check("ff_run_pass", 64'({done, pass}), 64'(2'b10));
`ifdef TSC_FIRST_FAIL_EN
    check("ff_idx", 64'(ff_idx), 7);
    check("ff_lane", 64'(ff_lane), 5);
    check("ff_act", 64'(ff_act), 64'(samp(7, 5) + 16'h0100));
    check("ff_exp", 64'(ff_exp), 64'(samp(7, 5)));
`else
    check("ff_tied", 64'({ff_idx, ff_lane, ff_act, ff_exp}), 0);
`endif

    // final report
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
